// File: rtl/cache_set_assoc_if.sv
// Bus bundle between one cache set and the cache top: request/response,
// victim evict stream, refill stream and set-wide invalidate.
interface cache_set_assoc_if #(
  parameter int CACHE_LINE_WIDTH = 6,
  parameter int TAG_WIDTH        = 18,
  parameter int NUM_WAYS         = 4
);
  localparam int OFF_W = CACHE_LINE_WIDTH - 2;
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic                 req_valid;
  logic                 req_ready;
  logic [TAG_WIDTH-1:0] req_tag;
  logic [OFF_W-1:0]     req_off;
  logic                 req_we;
  logic [31:0]          req_wdata;
  logic [3:0]           req_be;

  logic                 resp_valid;
  logic [31:0]          resp_data;
  logic [WAY_W-1:0]     resp_way;
  logic                 miss;

  logic                 evict_valid;
  logic                 evict_ready;
  logic [TAG_WIDTH-1:0] evict_tag;
  logic [OFF_W-1:0]     evict_off;
  logic [31:0]          evict_data;
  logic                 evict_last;

  logic                 refill_ready;
  logic                 refill_valid;
  logic [31:0]          refill_data;
  logic [TAG_WIDTH-1:0] refill_tag;

  logic                 inv_req;
  logic                 inv_done;
  logic                 busy;

  modport master (
    output req_valid, req_tag, req_off, req_we, req_wdata, req_be,
           evict_ready, refill_valid, refill_data, inv_req,
    input  req_ready, resp_valid, resp_data, resp_way, miss,
           evict_valid, evict_tag, evict_off, evict_data, evict_last,
           refill_ready, refill_tag, inv_done, busy
  );

  modport slave (
    input  req_valid, req_tag, req_off, req_we, req_wdata, req_be,
           evict_ready, refill_valid, refill_data, inv_req,
    output req_ready, resp_valid, resp_data, resp_way, miss,
           evict_valid, evict_tag, evict_off, evict_data, evict_last,
           refill_ready, refill_tag, inv_done, busy
  );
endinterface

// File: rtl/cache_set_assoc.sv
// One set of a NUM_WAYS-way cache: registered lookup, write-allocate, evict/refill/replay.
// Define CACHE_SET_PLRU_EN for tree pseudo-LRU replacement; default is an 8-bit LFSR.
module cache_set_assoc #(
  parameter int CACHE_LINE_WIDTH = 6,
  parameter int TAG_WIDTH        = 18,
  parameter int NUM_WAYS         = 4
) (
  input  logic              clk,
  input  logic              rst,
  cache_set_assoc_if.slave  bus
);
  localparam int OFF_W = CACHE_LINE_WIDTH - 2;
  localparam int WORDS = 2 ** OFF_W;
  localparam int WAY_W = $clog2(NUM_WAYS);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EVICT, S_REFILL} state_t;

  state_t               r_state, w_next;
  logic [31:0]          r_data [NUM_WAYS][WORDS];
  logic [TAG_WIDTH-1:0] r_tag  [NUM_WAYS];
  logic [NUM_WAYS-1:0]  r_valid, r_dirty;
  logic [OFF_W-1:0]     r_cnt;
  logic [WAY_W-1:0]     r_victim;
  logic                 r_inv_done;

  logic [TAG_WIDTH-1:0] r_req_tag;
  logic [OFF_W-1:0]     r_req_off;
  logic                 r_req_we;
  logic [31:0]          r_req_wdata;
  logic [3:0]           r_req_be;

  logic                 w_accept, w_inv, w_hit, w_last;
  logic                 w_evict_hs, w_refill_hs, w_refill_done, w_write_hit;
  logic [WAY_W-1:0]     w_hit_way, w_victim, w_repl_way;

  assign w_inv         = (r_state == S_IDLE) && bus.inv_req && !r_inv_done;
  assign w_accept      = (r_state == S_IDLE) && !bus.inv_req && bus.req_valid;
  assign w_evict_hs    = (r_state == S_EVICT) && bus.evict_ready;
  assign w_refill_hs   = (r_state == S_REFILL) && bus.refill_valid;
  assign w_last        = (r_cnt == OFF_W'(WORDS - 1));
  assign w_refill_done = w_refill_hs && w_last;
  assign w_write_hit   = (r_state == S_LOOKUP) && w_hit && r_req_we;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w] && (r_tag[w] == r_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // An empty way always beats the replacement policy; lowest index wins.
  always_comb begin
    w_victim = w_repl_way;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w]) w_victim = WAY_W'(w);
    end
  end

`ifdef CACHE_SET_PLRU_EN
  logic [NUM_WAYS-2:0] r_plru;
  logic                w_touch;
  logic [WAY_W-1:0]    w_touch_way;

  // Heap-ordered tree: node idx has children 2*idx+1 (lower half) and 2*idx+2.
  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] s,
                                                     input logic [WAY_W-1:0]    way);
    logic [WAY_W-1:0] idx;
    idx        = '0;
    plru_touch = s;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      plru_touch[idx] = ~way[l];
      idx = WAY_W'(2 * int'(idx) + 1 + int'(way[l]));
    end
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] s);
    logic [WAY_W-1:0] idx;
    idx         = '0;
    plru_victim = '0;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      plru_victim[l] = s[idx];
      idx = WAY_W'(2 * int'(idx) + 1 + int'(s[idx]));
    end
  endfunction

  assign w_touch     = ((r_state == S_LOOKUP) && w_hit) || w_refill_done;
  assign w_touch_way = w_refill_done ? r_victim : w_hit_way;
  assign w_repl_way  = plru_victim(r_plru);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_plru <= '0;
    else if (w_inv)   r_plru <= '0;
    else if (w_touch) r_plru <= plru_touch(r_plru, w_touch_way);
  end
`else
  logic [7:0] r_lfsr;

  assign w_repl_way = r_lfsr[WAY_W-1:0];

  // All-zero would lock the LFSR, so invalidate returns it to its seed instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_lfsr <= 8'h01;
    else if (w_inv) r_lfsr <= 8'h01;
    else            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
  end
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next           = r_state;
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_data    = '0;
    bus.resp_way     = '0;
    bus.miss         = 1'b0;
    bus.evict_valid  = 1'b0;
    bus.evict_tag    = '0;
    bus.evict_off    = '0;
    bus.evict_data   = '0;
    bus.evict_last   = 1'b0;
    bus.refill_ready = 1'b0;
    bus.refill_tag   = '0;
    unique case (r_state)
      S_IDLE: begin
        bus.req_ready = !bus.inv_req;
        if (w_accept) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          bus.resp_valid = 1'b1;
          bus.resp_data  = r_data[w_hit_way][r_req_off];
          bus.resp_way   = w_hit_way;
          w_next         = S_IDLE;
        end else begin
          bus.miss = 1'b1;
          w_next   = (r_valid[w_victim] && r_dirty[w_victim]) ? S_EVICT : S_REFILL;
        end
      end
      S_EVICT: begin
        bus.evict_valid = 1'b1;
        bus.evict_tag   = r_tag[r_victim];
        bus.evict_off   = r_cnt;
        bus.evict_data  = r_data[r_victim][r_cnt];
        bus.evict_last  = w_last;
        if (w_evict_hs && w_last) w_next = S_REFILL;
      end
      S_REFILL: begin
        bus.refill_ready = 1'b1;
        bus.refill_tag   = r_req_tag;
        if (w_refill_done) w_next = S_LOOKUP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.inv_done = r_inv_done;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_victim    <= '0;
      r_inv_done  <= 1'b0;
      r_req_tag   <= '0;
      r_req_off   <= '0;
      r_req_we    <= 1'b0;
      r_req_wdata <= '0;
      r_req_be    <= '0;
    end else begin
      r_state    <= w_next;
      r_inv_done <= w_inv;
      if (w_inv) begin
        r_valid <= '0;
        r_dirty <= '0;
      end
      if (w_accept) begin
        r_req_tag   <= bus.req_tag;
        r_req_off   <= bus.req_off;
        r_req_we    <= bus.req_we;
        r_req_wdata <= bus.req_wdata;
        r_req_be    <= bus.req_be;
      end
      if (w_write_hit) r_dirty[w_hit_way] <= 1'b1;
      // The victim stops being a valid line as soon as it is chosen, so a partly
      // refilled way can never look valid.
      if ((r_state == S_LOOKUP) && !w_hit) begin
        r_victim          <= w_victim;
        r_valid[w_victim] <= 1'b0;
        r_dirty[w_victim] <= 1'b0;
      end
      if (w_evict_hs || w_refill_hs) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_refill_done) begin
        r_valid[r_victim] <= 1'b1;
        r_dirty[r_victim] <= 1'b0;
      end
    end
  end

  // NOTE: tag/data storage is deliberately not reset; the valid bits guard every read.
  always_ff @(posedge clk) begin
    if (w_refill_hs)   r_data[r_victim][r_cnt] <= bus.refill_data;
    if (w_refill_done) r_tag[r_victim]         <= r_req_tag;
    if (w_write_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_req_be[b]) r_data[w_hit_way][r_req_off][8*b +: 8] <= r_req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cache_set_assoc.sv
// Directed bench for cache_set_assoc: miss/refill, hits, write merge, dirty evict with
// back-pressure, invalidate, and reset in the middle of a refill.
module tb_cache_set_assoc;
  localparam int CLW   = 6;
  localparam int TW    = 18;
  localparam int NW    = 4;
  localparam int WORDS = 16;
  localparam int WAY_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_set_assoc_if #(.CACHE_LINE_WIDTH(CLW), .TAG_WIDTH(TW), .NUM_WAYS(NW)) bus ();

  cache_set_assoc #(.CACHE_LINE_WIDTH(CLW), .TAG_WIDTH(TW), .NUM_WAYS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]      m_data [NW][WORDS];
  logic [TW-1:0]    m_tag  [NW];
  logic [7:0]       m_lfsr;
  logic [TW-1:0]    tg     [NW];
  int               cyc, evn;
  logic [31:0]      rd;
  logic [WAY_W-1:0] rw, exp_v;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, Galois right-shift, seed 1, one step per clock.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'h01;
    else      m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the set idle; returns at the negedge after accept.
  task automatic req(input logic [TW-1:0] tag, input logic [3:0] off, input logic we,
                     input logic [31:0] wdata, input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_tag   = tag;
    bus.req_off   = off;
    bus.req_we    = we;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic fill_model(input logic [WAY_W-1:0] way, input logic [TW-1:0] tag,
                            input logic [31:0] base);
    m_tag[way] = tag;
    for (int k = 0; k < WORDS; k++) m_data[way][k] = base + 32'(k);
  endtask

  // Drives evict/refill streams from the lookup cycle until resp_valid; cycles counted from accept.
  task automatic run_txn(input logic [31:0] base, input int stall_beat,
                         input logic [WAY_W-1:0] vic, output int cycles,
                         output logic [31:0] rdata, output logic [WAY_W-1:0] rway,
                         output int ev_beats);
    int  beat, stall_left;
    bit  done;
    cycles = 1; beat = 0; ev_beats = 0; stall_left = 3; done = 1'b0;
    rdata = '0; rway = '0;
    while (!done && cycles < 200) begin
      if (bus.resp_valid) begin
        rdata = bus.resp_data;
        rway  = bus.resp_way;
        done  = 1'b1;
      end else begin
        bus.evict_ready  = 1'b0;
        bus.refill_valid = 1'b0;
        if (bus.evict_valid) begin
          if (ev_beats == stall_beat && stall_left > 0) begin
            check("evict_hold_off", bus.evict_off, ev_beats);
            check("evict_hold_data", bus.evict_data, m_data[vic][ev_beats]);
            stall_left--;
          end else begin
            check("evict_tag", bus.evict_tag, m_tag[vic]);
            check("evict_off", bus.evict_off, ev_beats);
            check("evict_data", bus.evict_data, m_data[vic][ev_beats]);
            check("evict_last", bus.evict_last, ev_beats == WORDS - 1);
            bus.evict_ready = 1'b1;
            ev_beats++;
          end
        end
        if (bus.refill_ready) begin
          bus.refill_valid = 1'b1;
          bus.refill_data  = base + 32'(beat);
          beat++;
        end
        @(negedge clk);
        cycles++;
      end
    end
    bus.evict_ready  = 1'b0;
    bus.refill_valid = 1'b0;
    check("txn_done", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tg[0] = 18'h00010; tg[1] = 18'h00020; tg[2] = 18'h00030; tg[3] = 18'h00040;
    bus.req_valid = 0; bus.req_tag = '0; bus.req_off = '0; bus.req_we = 0;
    bus.req_wdata = '0; bus.req_be = '0; bus.evict_ready = 0; bus.refill_valid = 0;
    bus.refill_data = '0; bus.inv_req = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_miss", bus.miss, 0);
    check("rst_evict_valid", bus.evict_valid, 0);
    check("rst_refill_ready", bus.refill_ready, 0);
    check("rst_inv_done", bus.inv_done, 0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss, zero-wait refill
    req(tg[0], 4'd3, 1'b0, '0, '0);
    check("t1_miss", bus.miss, 1);
    check("t1_no_evict", bus.evict_valid, 0);
    run_txn(32'h100, -1, '0, cyc, rd, rw, evn);
    check("t1_data", rd, 32'h103);
    check("t1_way", rw, 0);
    check("t1_latency", cyc, 18);
    fill_model(2'd0, tg[0], 32'h100);
    @(negedge clk);
    check("t1_idle", bus.busy, 0);

    // Read hit
    req(tg[0], 4'd3, 1'b0, '0, '0);
    check("t2_resp_valid", bus.resp_valid, 1);
    check("t2_data", bus.resp_data, 32'h103);
    check("t2_way", bus.resp_way, 0);
    @(negedge clk);
    check("t2_idle", bus.busy, 0);
    check("t2_resp_pulse", bus.resp_valid, 0);

    // Write hit, low two bytes
    req(tg[0], 4'd3, 1'b1, 32'hAABBCCDD, 4'b0011);
    check("t3_wr_resp", bus.resp_valid, 1);
    check("t3_wr_old", bus.resp_data, 32'h103);
    m_data[0][3] = 32'h0000CCDD;
    @(negedge clk);
    req(tg[0], 4'd3, 1'b0, '0, '0);
    check("t3_rd_merged", bus.resp_data, 32'h0000CCDD);
    @(negedge clk);

    // Fill ways 1..3, dirty them, then touch 0..3 in order
    for (int i = 1; i < NW; i++) begin
      req(tg[i], 4'd1, 1'b0, '0, '0);
      check("t4_fill_miss", bus.miss, 1);
      run_txn(32'h100 * 32'(i + 1), -1, '0, cyc, rd, rw, evn);
      check("t4_fill_way", rw, i);
      check("t4_fill_data", rd, 32'h100 * 32'(i + 1) + 32'h1);
      fill_model(WAY_W'(i), tg[i], 32'h100 * 32'(i + 1));
      @(negedge clk);
    end
    for (int i = 1; i < NW; i++) begin
      req(tg[i], 4'd0, 1'b1, 32'hD0D0_0000 | 32'(i), 4'hF);
      check("t4_wr_way", bus.resp_way, i);
      m_data[i][0] = 32'hD0D0_0000 | 32'(i);
      @(negedge clk);
    end
    for (int i = 0; i < NW; i++) begin
      req(tg[i], 4'd1, 1'b0, '0, '0);
      check("t4_touch_way", bus.resp_way, i);
      @(negedge clk);
    end

    // Miss on a new tag: dirty victim evicted with 3-cycle stall at beat 5
    req(18'h00050, 4'd7, 1'b0, '0, '0);
    check("t4_new_miss", bus.miss, 1);
`ifdef CACHE_SET_PLRU_EN
    exp_v = 2'd0;
`else
    exp_v = m_lfsr[WAY_W-1:0];
`endif
    run_txn(32'h500, 5, exp_v, cyc, rd, rw, evn);
    check("t4_evict_beats", evn, WORDS);
    check("t4_data", rd, 32'h507);
    check("t4_way", rw, exp_v);
    check("t4_latency", cyc, 37);
    fill_model(exp_v, 18'h00050, 32'h500);
    @(negedge clk);

    // Invalidate beats a simultaneous request
    bus.inv_req = 1'b1;
    bus.req_valid = 1'b1; bus.req_tag = 18'h00050; bus.req_off = '0;
    #1;
    check("t5_req_ready", bus.req_ready, 0);
    @(negedge clk);
    check("t5_inv_done", bus.inv_done, 1);
    check("t5_not_accepted", bus.busy, 0);
    bus.inv_req = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    check("t5_inv_pulse", bus.inv_done, 0);
    req(18'h00050, 4'd7, 1'b0, '0, '0);
    check("t5_miss_after_inv", bus.miss, 1);
    check("t5_no_evict", bus.evict_valid, 0);
    run_txn(32'h600, -1, '0, cyc, rd, rw, evn);
    check("t5_way", rw, 0);
    check("t5_data", rd, 32'h607);
    check("t5_latency", cyc, 18);
    @(negedge clk);

    // Reset while refill beat 7 is being offered
    req(tg[1], 4'd2, 1'b0, '0, '0);
    check("t6_miss", bus.miss, 1);
    @(negedge clk);
    check("t6_refill_ready", bus.refill_ready, 1);
    check("t6_refill_tag", bus.refill_tag, tg[1]);
    for (int k = 0; k < 7; k++) begin
      bus.refill_valid = 1'b1;
      bus.refill_data  = 32'h700 + 32'(k);
      @(negedge clk);
    end
    bus.refill_data = 32'h707;
    rst = 1'b0;
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_req_ready", bus.req_ready, 1);
    check("t6_rst_refill_ready", bus.refill_ready, 0);
    bus.refill_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req(tg[1], 4'd2, 1'b0, '0, '0);
    check("t6_miss_again", bus.miss, 1);
    run_txn(32'h800, -1, '0, cyc, rd, rw, evn);
    check("t6_way", rw, 0);
    check("t6_data", rd, 32'h802);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
